phase_3_mult_xz: RTL and testbench

- Stage directly upstream of the post-adder/P-register stage.
- Multiplies the registered A1 and B1 operands (18x18) and holds the 36-bit product in the optional M register; the C operand is held in the optional C register.
- Drives the 48-bit X and Z operand buses that the post-adder consumes, selected by OPMODE[1:0] and OPMODE[3:2].
- Also exports the product as M.

---
 rtl/phase_3_mult_xz.sv | 102 ++++++++++
 tb/tb_phase_3_mult_xz.sv | 137 +++++++++++++
 2 files changed

// File: rtl/phase_3_mult_xz.sv
// Multiplier stage feeding the post-adder: 18x18 unsigned product with optional
// M register, optional C register, and the X/Z operand multiplexers.
module phase_3_mult_xz #(
    parameter int unsigned MREG    = 1,
    parameter int unsigned CREG    = 1,
    parameter int unsigned A_WIDTH = 18,
    parameter int unsigned C_WIDTH = 48
) (
    input  logic                   clk,
    input  logic                   RSTM,
    input  logic                   RSTC,
    input  logic                   CEM,
    input  logic                   CEC,
    input  logic [A_WIDTH-1:0]     A1,
    input  logic [A_WIDTH-1:0]     B1,
    input  logic [A_WIDTH-1:0]     D,
    input  logic [C_WIDTH-1:0]     C,
    input  logic [C_WIDTH-1:0]     PCIN,
    input  logic [C_WIDTH-1:0]     P,
    input  logic [3:0]             opmode,
    output logic [2*A_WIDTH-1:0]   M,
    output logic [C_WIDTH-1:0]     mux_x_out,
    output logic [C_WIDTH-1:0]     mux_z_out
);

    localparam int unsigned MWidth = 2 * A_WIDTH;

    logic [MWidth-1:0]  prod;
    logic [C_WIDTH-1:0] c_val;

    // Full-width unsigned product; operands zero-extended so nothing is truncated
    always_comb begin
        prod = MWidth'(A1) * MWidth'(B1);
    end

    if (MREG != 0) begin : g_mreg
        logic [MWidth-1:0] m_q;

        // M register: reset has priority over enable
        always_ff @(posedge clk) begin
            if (RSTM) begin
                m_q <= '0;
            end else if (CEM) begin
                m_q <= prod;
            end
        end

        assign M = m_q;
    end else begin : g_mbyp
        logic unused_m_ctrl;
        assign unused_m_ctrl = ^{RSTM, CEM};
        assign M = prod;
    end

    if (CREG != 0) begin : g_creg
        logic [C_WIDTH-1:0] c_q;

        // C register: reset has priority over enable
        always_ff @(posedge clk) begin
            if (RSTC) begin
                c_q <= '0;
            end else if (CEC) begin
                c_q <= C;
            end
        end

        assign c_val = c_q;
    end else begin : g_cbyp
        logic unused_c_ctrl;
        assign unused_c_ctrl = ^{RSTC, CEC};
        assign c_val = C;
    end

    // Only the low 12 bits of D take part in the X concatenation
    logic unused_d;
    assign unused_d = ^D[A_WIDTH-1:12];

    // X operand select; no sign extension, D sits in the MSBs of the concat
    always_comb begin
        mux_x_out = '0;
        unique case (opmode[1:0])
            2'b00: mux_x_out = '0;
            2'b01: mux_x_out = C_WIDTH'(M);
            2'b10: mux_x_out = P;
            2'b11: mux_x_out = C_WIDTH'({D[11:0], A1, B1});
            default: mux_x_out = '0;
        endcase
    end

    // Z operand select; opmode is registered upstream so no extra staging here
    always_comb begin
        mux_z_out = '0;
        unique case (opmode[3:2])
            2'b00: mux_z_out = '0;
            2'b01: mux_z_out = PCIN;
            2'b10: mux_z_out = P;
            2'b11: mux_z_out = c_val;
            default: mux_z_out = '0;
        endcase
    end

endmodule

// File: tb/tb_phase_3_mult_xz.sv
// Directed bench for phase_3_mult_xz: registered instance plus a bypass instance.
module tb_phase_3_mult_xz;

    logic        clk = 1'b0;
    logic        RSTM, RSTC, CEM, CEC;
    logic [17:0] A1, B1, D;
    logic [47:0] C, PCIN, P;
    logic [3:0]  opmode;

    logic [35:0] m_r, m_b;
    logic [47:0] x_r, z_r, x_b, z_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    phase_3_mult_xz #(.MREG(1), .CREG(1)) dut_reg (
        .clk(clk), .RSTM(RSTM), .RSTC(RSTC), .CEM(CEM), .CEC(CEC),
        .A1(A1), .B1(B1), .D(D), .C(C), .PCIN(PCIN), .P(P), .opmode(opmode),
        .M(m_r), .mux_x_out(x_r), .mux_z_out(z_r)
    );

    phase_3_mult_xz #(.MREG(0), .CREG(0)) dut_byp (
        .clk(clk), .RSTM(RSTM), .RSTC(RSTC), .CEM(CEM), .CEC(CEC),
        .A1(A1), .B1(B1), .D(D), .C(C), .PCIN(PCIN), .P(P), .opmode(opmode),
        .M(m_b), .mux_x_out(x_b), .mux_z_out(z_b)
    );

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RSTM = 1'b1; RSTC = 1'b1; CEM = 1'b0; CEC = 1'b0;
        A1 = '0; B1 = '0; D = '0; C = 48'h1234; PCIN = '0; P = '0;
        opmode = 4'b1101;
        #2;
        tick();
        check("rst_m", 48'(m_r), 48'd0);
        check("rst_x_m", x_r, 48'd0);
        check("rst_z_c", z_r, 48'd0);
        RSTM = 1'b0; RSTC = 1'b0;

        // Product latency
        CEM = 1'b1; A1 = 18'd3; B1 = 18'd5; opmode = 4'b0001;
        #1;
        check("lat_pre", 48'(m_r), 48'd0);
        tick();
        check("lat_m", 48'(m_r), 48'd15);
        check("lat_x", x_r, 48'd15);
        A1 = 18'h3FFFF; B1 = 18'h3FFFF;
        tick();
        check("max_m", 48'(m_r), 48'hFFFF80001);
        check("max_x", x_r, 48'hFFFF80001);

        // Clock enable hold
        A1 = 18'd3; B1 = 18'd5;
        tick();
        CEM = 1'b0; A1 = 18'd7; B1 = 18'd7;
        tick();
        check("ce_hold1", 48'(m_r), 48'd15);
        tick();
        check("ce_hold2", 48'(m_r), 48'd15);
        CEM = 1'b1;
        tick();
        check("ce_load", 48'(m_r), 48'd49);

        // Reset priority over enable, then recapture
        A1 = 18'd2; B1 = 18'd2; RSTM = 1'b1;
        tick();
        check("rstm_prio", 48'(m_r), 48'd0);
        RSTM = 1'b0;
        tick();
        check("rstm_rel", 48'(m_r), 48'd4);

        // C register reset and enable
        CEC = 1'b1; C = 48'h1234; opmode = 4'b1100;
        tick();
        check("c_load", z_r, 48'h1234);
        RSTC = 1'b1;
        tick();
        check("rstc_prio", z_r, 48'd0);
        RSTC = 1'b0; CEC = 1'b0; C = 48'h5555;
        tick();
        check("cec_hold", z_r, 48'd0);
        CEC = 1'b1;
        tick();
        check("cec_load", z_r, 48'h5555);

        // X/Z selection
        D = 18'hABC; A1 = 18'h00001; B1 = 18'h00002;
        P = 48'h1111; PCIN = 48'h2222; C = 48'h3333;
        tick();
        opmode = 4'b0011; #1;
        check("x_concat", x_r, 48'hABC000040002);
        opmode = 4'b0100; #1;
        check("z_pcin", z_r, 48'h2222);
        opmode = 4'b1000; #1;
        check("z_p", z_r, 48'h1111);
        opmode = 4'b1100; #1;
        check("z_c", z_r, 48'h3333);
        opmode = 4'b0010; #1;
        check("x_p", x_r, 48'h1111);
        opmode = 4'b0000; #1;
        check("x_zero", x_r, 48'd0);
        check("z_zero", z_r, 48'd0);

        // Bypass instance: same-cycle response, reset/enable ignored
        A1 = 18'd6; B1 = 18'd7; C = 48'd9; opmode = 4'b1101; CEM = 1'b0; CEC = 1'b0;
        #1;
        check("byp_m", 48'(m_b), 48'd42);
        check("byp_x", x_b, 48'd42);
        check("byp_z", z_b, 48'd9);
        RSTM = 1'b1; RSTC = 1'b1;
        tick();
        check("byp_rst_x", x_b, 48'd42);
        check("byp_rst_z", z_b, 48'd9);
        C = 48'd10; A1 = 18'd8; #1;
        check("byp_live_x", x_b, 48'd56);
        check("byp_live_z", z_b, 48'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
